updown_arb: RTL and testbench
=============================

# updown_arb

Round-robin scheduler that shares one W-bit up/down counter among NREQ requesters. Each requester asks for a timed count run of programmable length and direction. The block grants the counter to one requester at a time, sequences the run, and reports completion. It sits between client FSMs that need short delays or event counts and a single counter instance, so the design needs only one counter.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, counter and length width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level
- dir  in  NREQ  per-requester direction; 1 = up, 0 = down
- len  in  NREQ*W  flattened run lengths; requester i uses len[i*W +: W]
- grant  out  NREQ  one-hot owner of the counter; 0 when idle
- busy  out  1  counter allocated (state RUN or DONE)
- count  out  W  live counter value
- done  out  1  one-cycle completion pulse
- done_id  out  $clog2(NREQ)  owner index, valid while done=1

## Operation
- FSM states:
  - IDLE: no owner.
  - RUN: the owner's run is in progress.
  - DONE: one cycle that reports completion.
- Reset values:
  - state = IDLE
  - grant = 0
  - busy = 0
  - count = 0
  - done = 0
  - done_id = 0
  - rr_ptr = NREQ-1, so requester 0 wins the first arbitration.
- IDLE, with any req bit set:
  - Pick the first set bit, searching from rr_ptr+1 upward with wrap-around.
  - Latch the winner's id, len and dir.
  - Set rr_ptr to the winner.
  - Go to RUN.
- Load value on entry to RUN:
  - Up run: count = 0, target = len.
  - Down run: count = len, target = 0.
- RUN, each cycle:
  - If count == target: go to DONE, assert done, drive done_id = owner.
  - Otherwise: count += 1 (up) or count -= 1 (down).
- Counter arithmetic:
  - Modulo 2^W.
  - It never wraps during a run, because target is always reached first.
- DONE: lasts one cycle, then IDLE. grant and busy drop and done deasserts.
- count holds its last value in IDLE and DONE.
- len = 0 is legal. RUN lasts one cycle, count stays 0 and done follows.
- req and len are sampled only in IDLE. Changing a latched owner's len or dir mid-run has no effect.
- Simultaneous requests: exactly one grant. A losing requester must hold req. Starvation is bounded: every active requester is granted within NREQ runs.
- Reset asserted mid-run: everything returns to its reset values on the next edge, with no done pulse.

## Timing
- Call the edge that samples req in IDLE E0.
  - After E0: grant valid, busy = 1, count = start value.
  - After E_k, for k ≤ len: count = start ± k.
  - After E_(len+1): state DONE, done = 1.
  - After E_(len+2): IDLE, grant = 0.
- The earliest next grant is after E_(len+3).
- grant is high for len+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: UPDOWN_ARB_ABORT_EN.
- Defined:
  - If the owner's req drops while in RUN, go to IDLE on the next edge.
  - grant and busy clear and count freezes.
  - There is no done pulse for that run, and rr_ptr stays at the aborted owner.
- Not defined:
  - req is ignored after grant, and the run always completes with done.
  - A requester that dropped req still receives done.

## Structure
- Shared package updown_arb_pkg holds:
  - the state typedef (IDLE, RUN, DONE)
  - the default W = 4
  - a function for the round-robin next-index search
- Sub-module updown_core holds the counter datapath:
  - Inputs: clk, rst, load, load_val, en, up.
  - Output: count.
  - Synchronous reset to 0.
  - load has priority over en.
- The FSM and arbiter live in the top level.

## Test plan
- Reset: hold rst for 2 cycles with req = 4'b1111. All outputs are 0. After release, the first grant is 4'b0001.
- Single up run: req[2] = 1, dir[2] = 1, len[2] = 5. count steps 0..5, done pulses after E6 with done_id = 2, and grant is high for 7 cycles.
- Down run with len = 0: requester 1, dir = 0. RUN lasts one cycle, count = 0 and done fires after E1. Also check a down run with len = 15: count goes 15..0.
- Fairness: hold req = 4'b1111 with len = 2 on every requester. The grant order is 0, 1, 2, 3, 0, and consecutive done pulses are 5 cycles apart.
- Mid-run changes: alter len and dir of the owner during RUN. There is no effect on the count sequence. Also check rst asserted mid-RUN: outputs reach their reset values with no done pulse.
- Abort: requester 3, len = 10, with req[3] dropped after E4.
  - With UPDOWN_ARB_ABORT_EN: IDLE after E5, count frozen at 4, no done.
  - Without the macro: the run completes and done_id = 3.

Source files
------------

// File: rtl/updown_arb_pkg.sv
// Shared types and helpers for the updown_arb counter scheduler.
// Holds the FSM state type, the default counter width and the round-robin search.
package updown_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEFAULT = 4;
  localparam int NREQ_MAX  = 8;

  // Returns {found, index}: first set bit of req_vec after ptr, wrapping modulo nreq.
  function automatic logic [3:0] rr_next(input logic [7:0] req_vec,
                                         input logic [2:0] ptr,
                                         input int         nreq);
    logic       found;
    logic [2:0] idx;
    int         cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      cand = (int'(ptr) + k) % nreq;
      if (!found && (k <= nreq) && req_vec[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/updown_arb_core.sv
// Shared W-bit up/down counter used by updown_arb; load takes priority over count enable.
module updown_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= up ? (r_count + W'(1)) : (r_count - W'(1));
    end
  end

  assign count = r_count;

endmodule

// File: rtl/updown_arb.sv
// Round-robin scheduler granting one shared up/down counter to NREQ requesters.
// Optional macro UPDOWN_ARB_ABORT_EN: owner dropping req during RUN aborts the run.
module updown_arb
  import updown_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          dir,
  input  logic [NREQ*W-1:0]        len,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic [W-1:0]             count,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id
);

  localparam int IDW = $clog2(NREQ);

  state_t          r_state,   w_state_next;
  logic [IDW-1:0]  r_owner,   w_owner_next;
  logic [W-1:0]    r_target,  w_target_next;
  logic            r_up,      w_up_next;
  logic [NREQ-1:0] r_grant,   w_grant_next;
  logic            r_busy,    w_busy_next;
  logic            r_done,    w_done_next;
  logic [IDW-1:0]  r_done_id, w_done_id_next;
  logic [IDW-1:0]  r_rr_ptr,  w_rr_ptr_next;

  logic [7:0]      w_req_ext;
  logic [3:0]      w_pick;
  logic            w_found;
  logic [2:0]      w_pick_idx;
  logic [IDW-1:0]  w_win;
  logic [W-1:0]    w_win_len;
  logic            w_load;
  logic [W-1:0]    w_load_val;
  logic            w_en;
  logic [W-1:0]    w_count;

  always_comb begin
    w_req_ext           = '0;
    w_req_ext[NREQ-1:0] = req;
  end

  assign w_pick     = rr_next(w_req_ext, 3'(r_rr_ptr), NREQ);
  assign w_found    = w_pick[3];
  assign w_pick_idx = w_pick[2:0];
  assign w_win      = IDW'(w_pick_idx);
  assign w_win_len  = len[w_win*W +: W];

  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_target_next  = r_target;
    w_up_next      = r_up;
    w_grant_next   = r_grant;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_done_id_next = r_done_id;
    w_rr_ptr_next  = r_rr_ptr;
    w_load         = 1'b0;
    w_load_val     = '0;
    w_en           = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          // Up runs count 0..len, down runs count len..0.
          w_owner_next  = w_win;
          w_up_next     = dir[w_win];
          w_target_next = dir[w_win] ? w_win_len : '0;
          w_load        = 1'b1;
          w_load_val    = dir[w_win] ? '0 : w_win_len;
          w_grant_next  = NREQ'(1) << w_win;
          w_busy_next   = 1'b1;
          w_rr_ptr_next = w_win;
          w_state_next  = RUN;
        end
      end
      RUN: begin
`ifdef UPDOWN_ARB_ABORT_EN
        if (!req[r_owner]) begin
          w_grant_next = '0;
          w_busy_next  = 1'b0;
          w_state_next = IDLE;
        end else
`endif
        if (w_count == r_target) begin
          w_done_next    = 1'b1;
          w_done_id_next = r_owner;
          w_state_next   = DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      DONE: begin
        w_grant_next = '0;
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end
      default: begin
        w_grant_next = '0;
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_target  <= '0;
      r_up      <= 1'b0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_rr_ptr  <= IDW'(NREQ - 1);
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_target  <= w_target_next;
      r_up      <= w_up_next;
      r_grant   <= w_grant_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_done_id <= w_done_id_next;
      r_rr_ptr  <= w_rr_ptr_next;
    end
  end

  updown_core #(
    .W(W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .up       (r_up),
    .count    (w_count)
  );

  assign grant   = r_grant;
  assign busy    = r_busy;
  assign count   = w_count;
  assign done    = r_done;
  assign done_id = r_done_id;

endmodule

// File: tb/tb_updown_arb.sv
// Self-checking bench for updown_arb: directed scenarios plus random traffic
// against a run-level reference model (cycles elapsed since grant).
module tb_updown_arb;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   dir;
  logic [NREQ*W-1:0] len;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [W-1:0]      count;
  logic              done;
  logic [1:0]        done_id;

  updown_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .dir     (dir),
    .len     (len),
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a run is described by owner, length, direction and j = edges since grant.
  int m_act, m_j, m_owner, m_len, m_up, m_ptr, m_count, m_done, m_done_id;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int idx;
    m_done = 0;
    if (rst) begin
      m_act = 0; m_j = 0; m_owner = 0; m_len = 0; m_up = 0;
      m_ptr = NREQ - 1; m_count = 0; m_done_id = 0;
    end else if (!m_act) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!m_act && req[idx]) begin
          m_act   = 1;
          m_j     = 0;
          m_owner = idx;
          m_len   = int'(len[idx*W +: W]);
          m_up    = int'(dir[idx]);
          m_ptr   = idx;
          m_count = m_up ? 0 : m_len;
        end
      end
    end else begin
      m_j++;
`ifdef UPDOWN_ARB_ABORT_EN
      if (m_j <= m_len + 1 && !req[m_owner]) begin
        m_act = 0;
      end else
`endif
      if (m_j <= m_len) begin
        m_count = m_up ? m_j : (m_len - m_j);
      end else if (m_j == m_len + 1) begin
        m_done    = 1;
        m_done_id = m_owner;
      end else begin
        m_act = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("grant", int'(grant), m_act ? (1 << m_owner) : 0);
    chk("busy",  int'(busy),  m_act);
    chk("count", int'(count), m_count);
    chk("done",  int'(done),  m_done);
    if (m_done) begin
      chk("done_id", int'(done_id), m_done_id);
      $display("run done: id=%0d cycle=%0d", done_id, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic set_req(input int idx, input logic d, input int l);
    req             = NREQ'(1) << idx;
    dir[idx]        = d;
    len[idx*W +: W] = W'(l);
  endtask

  // Runs one request to completion; returns the number of cycles grant stayed high.
  task automatic run_one(input int idx, input logic d, input int l, output int hi);
    int guard;
    set_req(idx, d, l);
    hi = 0;
    guard = 0;
    while (grant == '0 && guard < 40) begin step(); guard++; end
    if (grant == '0) chk("grant_timeout", 0, 1);
    guard = 0;
    while (grant != '0 && guard < 40) begin
      hi++;
      if (done) req = '0;
      step();
      guard++;
    end
  endtask

  int hi;
  int grant_order[$];
  int done_cycles[$];
  int saw_done;
  logic [NREQ-1:0] prev_grant;

  initial begin
    rst = 1'b1; req = '1; dir = '0; len = {NREQ{W'(2)}};
    m_act = 0; m_ptr = NREQ - 1; m_count = 0; m_done = 0; m_done_id = 0;
    m_j = 0; m_owner = 0; m_len = 0; m_up = 0;

    // Reset with all requests active; first grant goes to requester 0.
    step(); step();
    chk("rst_grant", int'(grant), 0);
    chk("rst_count", int'(count), 0);
    rst = 1'b0;
    step();
    chk("first_grant", int'(grant), 1);
    req = '0;
    repeat (6) step();

    // Single up run, down len=0, down len=15.
    run_one(2, 1'b1, 5, hi);
    chk("grant_len_up5", hi, 7);
    step();
    run_one(1, 1'b0, 0, hi);
    chk("grant_len_dn0", hi, 2);
    step();
    run_one(0, 1'b0, 15, hi);
    chk("grant_len_dn15", hi, 17);
    step();

    // Fairness with everyone requesting len=2.
    rst = 1'b1; step(); rst = 1'b0;
    req = '1; dir = 4'b0101; len = {NREQ{W'(2)}};
    prev_grant = '0;
    repeat (26) begin
      step();
      if (grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < NREQ; i++) if (grant[i]) grant_order.push_back(i);
      end
      if (done) done_cycles.push_back(cyc);
      prev_grant = grant;
    end
    req = '0;
    repeat (5) step();
    if (grant_order.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", grant_order[i], i % NREQ);
    end else chk("rr_order_count", grant_order.size(), 5);
    if (done_cycles.size() >= 4) begin
      for (int i = 0; i < 3; i++) chk("done_gap", done_cycles[i+1] - done_cycles[i], 5);
    end else chk("done_count", done_cycles.size(), 4);

    // Owner's len/dir scrambled mid-run; the model keeps the latched values.
    set_req(1, 1'b1, 6);
    for (int g = 0; g < 40 && grant == '0; g++) step();
    for (int g = 0; g < 12; g++) begin
      dir = NREQ'($urandom); dir[1] = ~dir[1];
      len = (NREQ*W)'($urandom);
      if (done) req = '0;
      step();
    end
    req = '0; repeat (3) step();

    // Reset asserted in the middle of a run.
    set_req(3, 1'b0, 9);
    for (int g = 0; g < 40 && grant == '0; g++) step();
    repeat (3) step();
    req = '0; rst = 1'b1;
    step();
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_count", int'(count), 0);
    rst = 1'b0;
    step();

    // Abort scenario: requester 3, len 10, req dropped after E4.
    set_req(3, 1'b1, 10);
    for (int g = 0; g < 40 && grant == '0; g++) step();
    repeat (4) step();
    req[3] = 1'b0;
    step();
    saw_done = 0;
`ifdef UPDOWN_ARB_ABORT_EN
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(count), 4);
`else
    chk("noabort_busy", int'(busy), 1);
    chk("noabort_count", int'(count), 5);
`endif
    repeat (12) begin
      step();
      if (done) begin
        saw_done = 1;
        chk("abort_done_id", int'(done_id), 3);
      end
    end
`ifdef UPDOWN_ARB_ABORT_EN
    chk("abort_no_done", saw_done, 0);
`else
    chk("noabort_done", saw_done, 1);
`endif

    // Random traffic.
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 2) == 0) dir = NREQ'($urandom);
      if ($urandom_range(0, 2) == 0) len = (NREQ*W)'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
